// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-timer sequencer driving random_wait and timing the react press
// Optional feature macro: BEST_TIME_EN (tracks the minimum valid reaction time on best_time)
module reaction_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MAX_MS       = 999,
  parameter int RT_W         = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            react,
  input  logic            rwait_done,
  output logic            start_wait,
  output logic            led,
  output logic            busy,
  output logic [RT_W-1:0] rtime,
  output logic            rtime_valid,
  output logic            early,
  output logic            timeout,
  output logic [RT_W-1:0] best_time
);

  localparam int              PW         = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [RT_W-1:0] MS_LAST    = RT_W'(MAX_MS - 1);
  localparam logic [RT_W-1:0] MS_MAX     = RT_W'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_TIME  = 3'd2,
    S_DONE  = 3'd3,
    S_EARLY = 3'd4,
    S_TOUT  = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [RT_W-1:0] ms_cnt, ms_cnt_nxt;
  logic [RT_W-1:0] rtime_nxt;
  logic            start_wait_nxt, rtime_valid_nxt, early_nxt, timeout_nxt;
  logic            led_nxt, busy_nxt;
  logic            wrap;

  assign wrap = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      presc       <= '0;
      ms_cnt      <= '0;
      start_wait  <= 1'b0;
      led         <= 1'b0;
      busy        <= 1'b0;
      rtime       <= '0;
      rtime_valid <= 1'b0;
      early       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      ms_cnt      <= ms_cnt_nxt;
      start_wait  <= start_wait_nxt;
      led         <= led_nxt;
      busy        <= busy_nxt;
      rtime       <= rtime_nxt;
      rtime_valid <= rtime_valid_nxt;
      early       <= early_nxt;
      timeout     <= timeout_nxt;
    end
  end

  // Every output is computed one cycle ahead from the next state so it can be registered.
  always_comb begin
    state_nxt       = state;
    presc_nxt       = presc;
    ms_cnt_nxt      = ms_cnt;
    rtime_nxt       = rtime;
    start_wait_nxt  = 1'b0;
    rtime_valid_nxt = 1'b0;
    early_nxt       = early;
    timeout_nxt     = timeout;

    case (state)
      S_IDLE, S_DONE, S_EARLY, S_TOUT: begin
        if (start) begin
          state_nxt      = S_WAIT;
          start_wait_nxt = 1'b1;
          early_nxt      = 1'b0;
          timeout_nxt    = 1'b0;
        end
      end
      S_WAIT: begin
        if (react) begin
          state_nxt = S_EARLY;
          early_nxt = 1'b1;
          rtime_nxt = '0;
        end else if (rwait_done) begin
          state_nxt  = S_TIME;
          presc_nxt  = '0;
          ms_cnt_nxt = '0;
        end
      end
      S_TIME: begin
        presc_nxt = wrap ? '0 : presc + 1'b1;
        if (wrap && (ms_cnt < MS_MAX)) begin
          ms_cnt_nxt = ms_cnt + 1'b1;
        end
        // A press on the final wrap still counts as a valid reaction.
        if (react) begin
          state_nxt       = S_DONE;
          rtime_nxt       = ms_cnt;
          rtime_valid_nxt = 1'b1;
        end else if (wrap && (ms_cnt == MS_LAST)) begin
          state_nxt       = S_TOUT;
          rtime_nxt       = MS_MAX;
          timeout_nxt     = 1'b1;
          rtime_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    led_nxt  = (state_nxt == S_TIME);
    busy_nxt = (state_nxt == S_WAIT) || (state_nxt == S_TIME);
  end

`ifdef BEST_TIME_EN
  // Survives new trials; only reset restores the all-ones "no result yet" value.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_time <= '1;
    end else if ((state == S_TIME) && (state_nxt == S_DONE) && (rtime_nxt < best_time)) begin
      best_time <= rtime_nxt;
    end
  end
`else
  assign best_time = '0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - self-checking bench for reaction_ctrl with a result scoreboard
module tb_reaction_ctrl;

  localparam int TPM  = 4;
  localparam int MAXM = 20;
  localparam int RTW  = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           react = 1'b0;
  logic           rwait_done = 1'b0;
  logic           start_wait, led, busy, rtime_valid, early, timeout;
  logic [RTW-1:0] rtime, best_time;

  typedef struct packed {
    logic [RTW-1:0] rt;
    logic           to;
    logic [RTW-1:0] best;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [RTW-1:0] best_model;

  reaction_ctrl #(.TICKS_PER_MS(TPM), .MAX_MS(MAXM), .RT_W(RTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .react      (react),
    .rwait_done (rwait_done),
    .start_wait (start_wait),
    .led        (led),
    .busy       (busy),
    .rtime      (rtime),
    .rtime_valid(rtime_valid),
    .early      (early),
    .timeout    (timeout),
    .best_time  (best_time)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rtime_valid) obs_q.push_back('{rt: rtime, to: timeout, best: best_time});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_rwait();
    rwait_done = 1'b1; step(); rwait_done = 1'b0;
  endtask

  task automatic pulse_react();
    react = 1'b1; step(); react = 1'b0;
  endtask

  task automatic expect_result(input logic [RTW-1:0] rt, input logic to);
    if (!to && rt < best_model) best_model = rt;
`ifdef BEST_TIME_EN
    exp_q.push_back('{rt: rt, to: to, best: best_model});
`else
    exp_q.push_back('{rt: rt, to: to, best: '0});
`endif
  endtask

  task automatic score(input string tag);
    res_t e, o;
    chk({tag, "_nvalid"}, obs_q.size(), 1);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_rtime"}, o.rt, e.rt);
      chk({tag, "_timeout"}, o.to, e.to);
      chk({tag, "_best"}, o.best, e.best);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Start a trial and reach TIME; returns just after the rwait_done edge.
  task automatic arm(input string tag);
    pulse_start();
    chk({tag, "_sw_hi"}, start_wait, 1);
    chk({tag, "_busy"}, busy, 1);
    step();
    chk({tag, "_sw_lo"}, start_wait, 0);
    repeat (3) step();
    pulse_rwait();
    chk({tag, "_led_on"}, led, 1);
  endtask

  task automatic timed_trial(input string tag, input int n);
    arm(tag);
    repeat (4 * n) step();
    expect_result(RTW'(n), 1'b0);
    pulse_react();
    chk({tag, "_led_off"}, led, 0);
    chk({tag, "_busy_off"}, busy, 0);
    step();
    chk({tag, "_valid_pulse"}, rtime_valid, 0);
    score(tag);
  endtask

  initial begin
    best_model = '1;
    repeat (3) step();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sw", start_wait, 0);
    chk("rst_rtime", rtime, 0);
    chk("rst_valid", rtime_valid, 0);
    chk("rst_early", early, 0);
    chk("rst_timeout", timeout, 0);
`ifdef BEST_TIME_EN
    chk("rst_best", best_time, 10'h3ff);
`else
    chk("rst_best", best_time, 0);
`endif
    rst = 1'b0;
    repeat (6) step();

    // react while idle must be ignored
    pulse_react();
    chk("idle_react_busy", busy, 0);
    chk("idle_react_early", early, 0);

    timed_trial("t9", 9);
    timed_trial("t5", 5);
    timed_trial("t12", 12);

    // Timeout: 80 cycles of led, then TOUT
    arm("tout");
    repeat (79) step();
    chk("tout_led_last", led, 1);
    expect_result(RTW'(MAXM), 1'b1);
    step();
    chk("tout_led_off", led, 0);
    chk("tout_flag", timeout, 1);
    chk("tout_busy", busy, 0);
    step();
    score("tout");

    // Next start clears timeout
    pulse_start();
    chk("clr_timeout", timeout, 0);
    // start during WAIT: no second start_wait
    pulse_start();
    chk("wait_start_ignored", start_wait, 0);
    chk("wait_still_busy", busy, 1);
    // Early press
    repeat (2) step();
    pulse_react();
    chk("early_flag", early, 1);
    chk("early_rtime", rtime, 0);
    chk("early_busy", busy, 0);
    chk("early_novalid", rtime_valid, 0);
    pulse_rwait();
    step();
    chk("early_led_stays", led, 0);
    chk("early_nvalid", obs_q.size(), 0);
    pulse_start();
    chk("clr_early", early, 0);

    // react and rwait_done together in WAIT -> EARLY
    repeat (2) step();
    react = 1'b1; rwait_done = 1'b1;
    step();
    react = 1'b0; rwait_done = 1'b0;
    chk("sim_early", early, 1);
    chk("sim_led", led, 0);

    // react on the final wrap -> DONE with 19
    arm("fin");
    repeat (79) step();
    expect_result(RTW'(MAXM - 1), 1'b0);
    pulse_react();
    chk("fin_timeout", timeout, 0);
    step();
    score("fin");

    // reset in TIME aborts without rtime_valid
    arm("rst");
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_led", led, 0);
    chk("rstmid_busy", busy, 0);
    repeat (90) step();
    chk("rstmid_nvalid", obs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
